// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake and result flags.
// Optional ones-count output enabled by defining LU_POPCNT_EN.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [3:0]                 sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           y,
  output logic                       flag_zero,
  output logic                       flag_ones,
  output logic                       flag_par,
  output logic                       flag_ill
`ifdef LU_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  typedef enum logic [3:0] {
    OpPass = 4'b0000,
    OpAnd  = 4'b0010,
    OpOr   = 4'b0011,
    OpXor  = 4'b0100,
    OpNotA = 4'b0101,
    OpNand = 4'b0110,
    OpNor  = 4'b0111,
    OpXnor = 4'b1000,
    OpAndn = 4'b1001
  } op_e;

  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       sel_q;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] res_d;
  logic             ill_d;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  // Reset empties both stages, so advertise readiness while it is asserted.
  assign in_ready = s1_adv || !rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        sel_q <= sel;
      end
    end
  end

  always_comb begin
    res_d = '0;
    ill_d = 1'b0;
    case (sel_q)
      OpPass:  res_d = a_q;
      OpAnd:   res_d = a_q & b_q;
      OpOr:    res_d = a_q | b_q;
      OpXor:   res_d = a_q ^ b_q;
      OpNotA:  res_d = ~a_q;
      OpNand:  res_d = ~(a_q & b_q);
      OpNor:   res_d = ~(a_q | b_q);
      OpXnor:  res_d = ~(a_q ^ b_q);
      OpAndn:  res_d = a_q & ~b_q;
      default: ill_d = 1'b1;
    endcase
  end

`ifdef LU_POPCNT_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d = cnt_d + CntW'(res_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      popcnt <= '0;
    end else if (s2_adv && s1_valid_q) begin
      popcnt <= cnt_d;
    end
  end
`endif

  // Result and flags only load with a real beat, so they stay put through stalls and bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      flag_zero <= 1'b0;
      flag_ones <= 1'b0;
      flag_par  <= 1'b0;
      flag_ill  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        y         <= res_d;
        flag_zero <= (res_d == '0);
        flag_ones <= &res_d;
        flag_par  <= ^res_d;
        flag_ill  <= ill_d;
      end
    end
  end

endmodule
